// File: rtl/rd_frame_dpram.sv
// Single-clock true dual-port RAM: line/prefetch ring buffer of the video read path.
// Optional macro RD_FRAME_DPRAM_OUT_REG_EN adds an output register per port (read latency 2).
module rd_frame_dpram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wr_data,
    input  logic                  a_wr_en,
    output logic [DATA_WIDTH-1:0] a_rd_data,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wr_data,
    input  logic                  b_wr_en,
    output logic [DATA_WIDTH-1:0] b_rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] a_rd_q;
    logic [DATA_WIDTH-1:0] b_rd_q;

    // Storage is never reset. Port A's write is issued last, so on a same-address
    // dual write the A data is the one that lands.
    always_ff @(posedge clk) begin
        if (b_wr_en) begin
            mem[b_addr] <= b_wr_data;
        end
        if (a_wr_en) begin
            mem[a_addr] <= a_wr_data;
        end
    end

    // Read registers sample the pre-write contents, giving read-first behaviour
    // for both same-port and cross-port collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rd_q <= '0;
            b_rd_q <= '0;
        end else begin
            a_rd_q <= mem[a_addr];
            b_rd_q <= mem[b_addr];
        end
    end

`ifdef RD_FRAME_DPRAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] a_rd_p;
    logic [DATA_WIDTH-1:0] b_rd_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rd_p <= '0;
            b_rd_p <= '0;
        end else begin
            a_rd_p <= a_rd_q;
            b_rd_p <= b_rd_q;
        end
    end

    assign a_rd_data = a_rd_p;
    assign b_rd_data = b_rd_p;
`else
    assign a_rd_data = a_rd_q;
    assign b_rd_data = b_rd_q;
`endif

endmodule

// File: tb/tb_rd_frame_dpram.sv
// Directed self-checking bench for rd_frame_dpram; follows RD_FRAME_DPRAM_OUT_REG_EN for latency.
module tb_rd_frame_dpram;

    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 128;
`ifdef RD_FRAME_DPRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wr_data;
    logic                  a_wr_en;
    logic [DATA_WIDTH-1:0] a_rd_data;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wr_data;
    logic                  b_wr_en;
    logic [DATA_WIDTH-1:0] b_rd_data;

    int checks = 0;
    int errors = 0;

    rd_frame_dpram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_addr   (a_addr),
        .a_wr_data(a_wr_data),
        .a_wr_en  (a_wr_en),
        .a_rd_data(a_rd_data),
        .b_addr   (b_addr),
        .b_wr_data(b_wr_data),
        .b_wr_en  (b_wr_en),
        .b_rd_data(b_rd_data)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it before sampling or driving.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_writes();
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_addr = '0; b_addr = '0;
        a_wr_data = '0; b_wr_data = '0;
        idle_writes();
        tick(2);
        checks++;
        if (a_rd_data !== '0) begin
            errors++; $display("FAIL reset_a got %h exp 0", a_rd_data);
        end
        checks++;
        if (b_rd_data !== '0) begin
            errors++; $display("FAIL reset_b got %h exp 0", b_rd_data);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_readback();
        logic [DATA_WIDTH-1:0] exp;
        for (int i = 0; i < 16; i++) begin
            a_addr = ADDR_WIDTH'(i);
            a_wr_data = DATA_WIDTH'(i + 1);
            a_wr_en = 1'b1;
            tick(1);
        end
        idle_writes();
        // Stream addresses on B; after edge i the output shows address i-LAT+1.
        for (int i = 0; i < 16 + LAT - 1; i++) begin
            b_addr = ADDR_WIDTH'((i < 16) ? i : 15);
            tick(1);
            if (i >= LAT - 1) begin
                exp = DATA_WIDTH'(i - LAT + 2);
                checks++;
                if (b_rd_data !== exp) begin
                    errors++; $display("FAIL readback[%0d] got %h exp %h", i - LAT + 1, b_rd_data, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        a_addr = '0; b_addr = '0;
        tick(LAT);
        checks++;
        if (b_rd_data !== DATA_WIDTH'(1)) begin
            errors++; $display("FAIL prereset_b got %h exp 1", b_rd_data);
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if (a_rd_data !== '0 || b_rd_data !== '0) begin
            errors++; $display("FAIL rst_edge1 got a=%h b=%h exp 0", a_rd_data, b_rd_data);
        end
        tick(1);
        checks++;
        if (a_rd_data !== '0 || b_rd_data !== '0) begin
            errors++; $display("FAIL rst_edge2 got a=%h b=%h exp 0", a_rd_data, b_rd_data);
        end
        rst = 1'b0;
        tick(LAT);
        checks++;
        if (a_rd_data !== DATA_WIDTH'(1)) begin
            errors++; $display("FAIL retained_a got %h exp 1", a_rd_data);
        end
        checks++;
        if (b_rd_data !== DATA_WIDTH'(1)) begin
            errors++; $display("FAIL retained_b got %h exp 1", b_rd_data);
        end
    endtask

    task automatic test_wrap();
        logic [DATA_WIDTH-1:0] pat_a;
        logic [DATA_WIDTH-1:0] pat_5;
        pat_a = {(DATA_WIDTH/8){8'hAA}};
        pat_5 = {(DATA_WIDTH/8){8'h55}};
        a_wr_en = 1'b1;
        a_addr = 10'h3FF; a_wr_data = pat_a;
        tick(1);
        a_addr = 10'h000; a_wr_data = pat_5;
        tick(1);
        idle_writes();
        b_addr = 10'h3FF;
        tick(LAT);
        checks++;
        if (b_rd_data !== pat_a) begin
            errors++; $display("FAIL wrap_3ff got %h exp %h", b_rd_data, pat_a);
        end
        b_addr = 10'h000;
        tick(LAT);
        checks++;
        if (b_rd_data !== pat_5) begin
            errors++; $display("FAIL wrap_000 got %h exp %h", b_rd_data, pat_5);
        end
    endtask

    task automatic test_collision();
        a_addr = 10'd5; a_wr_data = DATA_WIDTH'(8'h11); a_wr_en = 1'b1;
        b_addr = 10'd100;
        tick(1);
        // A writes 0x22 to 5 while B reads 5 in the same cycle.
        a_wr_data = DATA_WIDTH'(8'h22);
        b_addr = 10'd5;
        tick(1);
        idle_writes();
        a_addr = 10'd100;
        if (LAT > 1) tick(LAT - 1);
        checks++;
        if (b_rd_data !== DATA_WIDTH'(8'h11)) begin
            errors++; $display("FAIL collision_old got %h exp 11", b_rd_data);
        end
        tick(1);
        checks++;
        if (b_rd_data !== DATA_WIDTH'(8'h22)) begin
            errors++; $display("FAIL collision_new got %h exp 22", b_rd_data);
        end
        // Mirror case: B writes 0x66 to 5 while A reads 5.
        b_wr_data = DATA_WIDTH'(8'h66); b_wr_en = 1'b1;
        a_addr = 10'd5;
        tick(1);
        idle_writes();
        if (LAT > 1) tick(LAT - 1);
        checks++;
        if (a_rd_data !== DATA_WIDTH'(8'h22)) begin
            errors++; $display("FAIL collision_b_old got %h exp 22", a_rd_data);
        end
        tick(1);
        checks++;
        if (a_rd_data !== DATA_WIDTH'(8'h66)) begin
            errors++; $display("FAIL collision_b_new got %h exp 66", a_rd_data);
        end
    endtask

    task automatic test_same_port();
        a_addr = 10'd7; a_wr_data = DATA_WIDTH'(8'h33); a_wr_en = 1'b1;
        tick(1);
        a_wr_data = DATA_WIDTH'(8'h44);
        tick(1);
        idle_writes();
        if (LAT > 1) tick(LAT - 1);
        checks++;
        if (a_rd_data !== DATA_WIDTH'(8'h33)) begin
            errors++; $display("FAIL same_port_old got %h exp 33", a_rd_data);
        end
        tick(1);
        checks++;
        if (a_rd_data !== DATA_WIDTH'(8'h44)) begin
            errors++; $display("FAIL same_port_new got %h exp 44", a_rd_data);
        end
    endtask

    task automatic test_dual_write();
        a_addr = 10'd9; a_wr_data = DATA_WIDTH'(8'hA0); a_wr_en = 1'b1;
        b_addr = 10'd9; b_wr_data = DATA_WIDTH'(8'hB0); b_wr_en = 1'b1;
        tick(1);
        idle_writes();
        tick(LAT);
        checks++;
        if (a_rd_data !== DATA_WIDTH'(8'hA0)) begin
            errors++; $display("FAIL dual_same_a got %h exp a0", a_rd_data);
        end
        checks++;
        if (b_rd_data !== DATA_WIDTH'(8'hA0)) begin
            errors++; $display("FAIL dual_same_b got %h exp a0", b_rd_data);
        end
        a_addr = 10'd20; a_wr_data = DATA_WIDTH'(16'hC0C0); a_wr_en = 1'b1;
        b_addr = 10'd21; b_wr_data = DATA_WIDTH'(16'hD0D0); b_wr_en = 1'b1;
        tick(1);
        idle_writes();
        a_addr = 10'd21; b_addr = 10'd20;
        tick(LAT);
        checks++;
        if (a_rd_data !== DATA_WIDTH'(16'hD0D0)) begin
            errors++; $display("FAIL dual_diff_a got %h exp d0d0", a_rd_data);
        end
        checks++;
        if (b_rd_data !== DATA_WIDTH'(16'hC0C0)) begin
            errors++; $display("FAIL dual_diff_b got %h exp c0c0", b_rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_readback();
        test_reset_mid();
        test_wrap();
        test_collision();
        test_same_port();
        test_dual_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
